store_buffer: RTL and testbench

- Posted-write FIFO directly downstream of the store control stage.
- Accepts word-aligned write beats (address, byte-enables, lane-positioned data) from the MEM stage and drains them in order to the data-memory port with a req/gnt handshake.
- Lets the pipeline retire stores without waiting for memory.
- Provides a load-hazard flag so the load path stalls on any pending overlapping store.

---
 rtl/store_buffer.sv | 99 +++++++++
 tb/tb_store_buffer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-write FIFO between store control and the data-memory port.
// Drains word-aligned beats in order over req/gnt and flags loads that overlap pending stores.
module store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     st_valid_i,
  input  logic [ADDR_W-1:0]        st_addr_i,
  input  logic [31:0]              st_wdata_i,
  input  logic [3:0]               st_be_i,
  output logic                     st_ready_o,
  output logic                     mem_req_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [31:0]              mem_wdata_o,
  output logic [3:0]               mem_be_o,
  input  logic                     mem_gnt_i,
  input  logic                     ld_valid_i,
  input  logic [ADDR_W-1:0]        ld_addr_i,
  input  logic [3:0]               ld_be_i,
  output logic                     ld_hazard_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-3:0] addr_q  [DEPTH];
  logic [31:0]       wdata_q [DEPTH];
  logic [3:0]        be_q    [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic             hz_buf;
  logic             hz_in;
  logic [PTR_W-1:0] slot;

  // Readiness looks only at the registered count: a full buffer never takes a beat,
  // even when the head drains in the same cycle.
  assign st_ready_o = rst_ni && (count < FULL_CNT);
  assign push       = st_valid_i && st_ready_o && (st_be_i != '0);
  assign mem_req_o  = rst_ni && (count != '0);
  assign pop        = mem_req_o && mem_gnt_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[wr_ptr]  <= st_addr_i[ADDR_W-1:2];
      wdata_q[wr_ptr] <= st_wdata_i;
      be_q[wr_ptr]    <= st_be_i;
    end
  end

  assign mem_addr_o  = rst_ni ? {addr_q[rd_ptr], 2'b00} : '0;
  assign mem_wdata_o = rst_ni ? wdata_q[rd_ptr] : '0;
  assign mem_be_o    = rst_ni ? be_q[rd_ptr] : '0;
  assign empty_o     = !rst_ni || (count == '0);
  assign count_o     = rst_ni ? count : '0;

  // An entry is live when its distance from the head (mod DEPTH) is below count.
  always_comb begin
    hz_buf = 1'b0;
    slot   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot = PTR_W'(i) - rd_ptr;
      if (({1'b0, slot} < count) &&
          (addr_q[i] == ld_addr_i[ADDR_W-1:2]) &&
          ((be_q[i] & ld_be_i) != '0))
        hz_buf = 1'b1;
    end
  end

  assign hz_in = push && (st_addr_i[ADDR_W-1:2] == ld_addr_i[ADDR_W-1:2]) &&
                 ((st_be_i & ld_be_i) != '0);

  assign ld_hazard_o = rst_ni && ld_valid_i && (hz_buf || hz_in);

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: a negedge scoreboard checks occupancy, drain order and hazards
// every cycle, while directed sequences and a hazard vector table check fixed expectations.
module tb_store_buffer;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic        st_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [3:0]  ld_be;
  logic        ld_hazard;
  logic        empty;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } beat_t;

  beat_t exp_q[$];

  typedef struct {
    string       name;
    logic        ld_v;
    logic [31:0] ld_a;
    logic [3:0]  ld_b;
    logic        st_v;
    logic [31:0] st_a;
    logic [3:0]  st_b;
    logic        exp;
  } hz_vec_t;

  hz_vec_t vecs[8];

  store_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .st_valid_i  (st_valid),
    .st_addr_i   (st_addr),
    .st_wdata_i  (st_wdata),
    .st_be_i     (st_be),
    .st_ready_o  (st_ready),
    .mem_req_o   (mem_req),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_be_o    (mem_be),
    .mem_gnt_i   (mem_gnt),
    .ld_valid_i  (ld_valid),
    .ld_addr_i   (ld_addr),
    .ld_be_i     (ld_be),
    .ld_hazard_o (ld_hazard),
    .empty_o     (empty),
    .count_o     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_st(input logic v, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be);
    st_valid = v;
    st_addr  = a;
    st_wdata = d;
    st_be    = be;
  endtask

  // Scoreboard: predicts the buffer from the stimulus seen this cycle, then applies
  // the pushes/pops that the coming rising edge will perform.
  always @(negedge clk) begin
    logic  rdy;
    logic  hz;
    beat_t b;
    if (!rst_n) begin
      chk("rst_ready", st_ready, 0);
      chk("rst_req", mem_req, 0);
      chk("rst_hazard", ld_hazard, 0);
      chk("rst_empty", empty, 1);
      chk("rst_count", count, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_be", mem_be, 0);
      exp_q.delete();
    end else begin
      rdy = (exp_q.size() < 4);
      chk("sb_count", count, exp_q.size());
      chk("sb_ready", st_ready, rdy);
      chk("sb_req", mem_req, exp_q.size() != 0);
      chk("sb_empty", empty, exp_q.size() == 0);
      if (exp_q.size() != 0) begin
        chk("sb_head_addr", mem_addr, exp_q[0].addr);
        chk("sb_head_data", mem_wdata, exp_q[0].data);
        chk("sb_head_be", mem_be, exp_q[0].be);
      end
      hz = 1'b0;
      foreach (exp_q[i])
        if (exp_q[i].addr[31:2] == ld_addr[31:2] && (exp_q[i].be & ld_be) != 0) hz = 1'b1;
      if (st_valid && rdy && st_be != 0 && st_addr[31:2] == ld_addr[31:2] &&
          (st_be & ld_be) != 0) hz = 1'b1;
      chk("sb_hazard", ld_hazard, ld_valid && hz);
      if (exp_q.size() != 0 && mem_gnt) void'(exp_q.pop_front());
      if (st_valid && rdy && st_be != 0) begin
        b.addr = {st_addr[31:2], 2'b00};
        b.data = st_wdata;
        b.be   = st_be;
        exp_q.push_back(b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"hz_same_word",   1'b1, 32'h202, 4'b1100, 1'b0, 32'h0,   4'b0000, 1'b1};
    vecs[1] = '{"hz_disjoint",    1'b1, 32'h200, 4'b0011, 1'b0, 32'h0,   4'b0000, 1'b0};
    vecs[2] = '{"hz_next_word",   1'b1, 32'h204, 4'b1111, 1'b0, 32'h0,   4'b0000, 1'b0};
    vecs[3] = '{"hz_no_load",     1'b0, 32'h200, 4'b1100, 1'b0, 32'h0,   4'b0000, 1'b0};
    vecs[4] = '{"hz_one_lane",    1'b1, 32'h201, 4'b0100, 1'b0, 32'h0,   4'b0000, 1'b1};
    vecs[5] = '{"hz_zero_be_in",  1'b1, 32'h300, 4'b1111, 1'b1, 32'h300, 4'b0000, 1'b0};
    vecs[6] = '{"hz_incoming",    1'b1, 32'h300, 4'b1111, 1'b1, 32'h300, 4'b0001, 1'b1};
    vecs[7] = '{"hz_held_lane",   1'b1, 32'h300, 4'b0010, 1'b0, 32'h0,   4'b0000, 1'b0};

    rst_n = 1'b0; mem_gnt = 1'b0;
    drive_st(0, 0, 0, 0);
    ld_valid = 1'b0; ld_addr = '0; ld_be = '0;

    // Reset: outputs forced even with a store and an overlapping load offered.
    repeat (2) step();
    drive_st(1, 32'h40, 32'h1, 4'hF);
    ld_valid = 1'b1; ld_addr = 32'h40; ld_be = 4'hF;
    #1;
    chk("reset_ready", st_ready, 0);
    chk("reset_hazard", ld_hazard, 0);
    chk("reset_count", count, 0);
    step();
    drive_st(0, 0, 0, 0);
    ld_valid = 1'b0;
    rst_n = 1'b1;

    // 1: single store, held by gnt low, then drained.
    step();
    drive_st(1, 32'h100, 32'hAB, 4'b0001);
    step();
    drive_st(0, 0, 0, 0);
    chk("t1_req", mem_req, 1);
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_be", mem_be, 4'b0001);
    chk("t1_count", count, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t1_hold_addr", mem_addr, 32'h100);
      chk("t1_hold_data", mem_wdata, 32'hAB);
      chk("t1_hold_req", mem_req, 1);
    end
    mem_gnt = 1'b1;
    step();
    chk("t1_empty", empty, 1);
    chk("t1_req_low", mem_req, 0);
    step();
    chk("t1_gnt_when_empty", count, 0);
    mem_gnt = 1'b0;

    // 2: fill to full, offer a fifth, then drain with wrap-around refill.
    for (int k = 0; k < 4; k++) begin
      step();
      drive_st(1, 32'h10 + 4 * k, 32'hA0 + k, 4'hF);
    end
    step();
    chk("t2_full_ready", st_ready, 0);
    chk("t2_full_count", count, 4);
    drive_st(1, 32'h20, 32'hA4, 4'hF);
    step();
    chk("t2_fifth_count", count, 4);
    chk("t2_fifth_ready", st_ready, 0);
    chk("t2_head0", mem_addr, 32'h10);
    mem_gnt = 1'b1;
    step();
    chk("t2_head1", mem_addr, 32'h14);
    chk("t2_no_push_on_full_pop", count, 3);
    chk("t2_ready_again", st_ready, 1);
    step();
    drive_st(0, 0, 0, 0);
    chk("t2_head2", mem_addr, 32'h18);
    chk("t2_count_pushpop", count, 3);
    step();
    chk("t2_head3", mem_addr, 32'h1C);
    step();
    chk("t2_wrap_addr", mem_addr, 32'h20);
    chk("t2_wrap_data", mem_wdata, 32'hA4);
    step();
    chk("t2_drained", empty, 1);

    // 3: gnt high, one push per cycle; each beat is the head one cycle later.
    for (int k = 0; k < 10; k++) begin
      step();
      if (k > 0) begin
        chk("t3_addr", mem_addr, 32'h500 + 4 * (k - 1));
        chk("t3_count", count, 1);
      end
      drive_st(1, 32'h500 + 4 * k, 32'h5000 + k, 4'hF);
    end
    step();
    chk("t3_last_addr", mem_addr, 32'h524);
    drive_st(0, 0, 0, 0);
    step();
    chk("t3_empty", empty, 1);
    mem_gnt = 1'b0;

    // 4: hazard vectors against a held store 0x200 be 1100.
    step();
    drive_st(1, 32'h200, 32'hAABB0000, 4'b1100);
    step();
    drive_st(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      ld_valid = vecs[i].ld_v; ld_addr = vecs[i].ld_a; ld_be = vecs[i].ld_b;
      drive_st(vecs[i].st_v, vecs[i].st_a, 32'h77, vecs[i].st_b);
      #1;
      chk(vecs[i].name, ld_hazard, vecs[i].exp);
    end
    step();
    drive_st(0, 0, 0, 0);
    ld_valid = 1'b1; ld_addr = 32'h200; ld_be = 4'b1000; mem_gnt = 1'b1;
    #1;
    chk("hz_popping_head", ld_hazard, 1);
    step();
    #1;
    chk("hz_after_pop", ld_hazard, 0);
    step();
    ld_addr = 32'h300; ld_be = 4'b0001;
    #1;
    chk("hz_stale_storage", ld_hazard, 0);
    ld_valid = 1'b0; mem_gnt = 1'b0;

    // 5: zero byte-enable beat is dropped; misaligned address is word-aligned.
    step();
    drive_st(1, 32'h103, 32'h55, 4'b0000);
    step();
    drive_st(0, 0, 0, 0);
    chk("t5_count", count, 0);
    chk("t5_req", mem_req, 0);
    chk("t5_ready", st_ready, 1);
    drive_st(1, 32'h107, 32'h1200, 4'b0010);
    step();
    drive_st(0, 0, 0, 0);
    chk("t5_aligned_addr", mem_addr, 32'h104);
    chk("t5_be", mem_be, 4'b0010);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("t5_empty", empty, 1);

    // 6: reset with three entries held and gnt high discards everything.
    for (int k = 0; k < 3; k++) begin
      step();
      drive_st(1, 32'h600 + 4 * k, 32'h6000 + k, 4'hF);
    end
    step();
    drive_st(0, 0, 0, 0);
    chk("t6_count_before", count, 3);
    rst_n = 1'b0; mem_gnt = 1'b1;
    #1;
    chk("t6_ready_in_reset", st_ready, 0);
    chk("t6_req_in_reset", mem_req, 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("t6_count_after", count, 0);
    chk("t6_empty_after", empty, 1);
    chk("t6_req_after", mem_req, 0);
    step();
    chk("t6_no_stale", mem_req, 0);
    mem_gnt = 1'b0;
    drive_st(1, 32'h700, 32'h7777, 4'hF);
    step();
    drive_st(0, 0, 0, 0);
    chk("t6_new_head", mem_addr, 32'h700);
    chk("t6_new_count", count, 1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("t6_final_empty", empty, 1);
    step();
    chk("sb_leftover", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
